// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t    : FSM encoding (FETCH, HOLD, DROP)
//   NOP_INST         : instruction word loaded into IF/ID as a bubble
//   DEFAULT_RESET_PC : default first fetch address after reset
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for an instruction that arrived while the
// pipeline was stalled.
//   clk, rst      : clock and asynchronous active-low reset
//   load          : capture inst_in/pc4_in and mark the entry valid
//   clear         : empty the entry (wins over load)
//   inst_in       : instruction word to capture
//   pc4_in        : PC+4 belonging to that instruction
//   inst, pc4     : stored entry
//   valid         : entry holds a captured instruction
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] inst,
    output logic [31:0] pc4,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst  <= NOP_INST;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (clear) begin
            inst  <= NOP_INST;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (load) begin
            inst  <= inst_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one request at a time to instruction
// memory and fills the IF/ID pipeline register, honouring stall and flush
// requests from the hazard unit.
//   clk, rst    : clock and asynchronous active-low reset
//   pcWrite     : PC enable (0 = stall)
//   IFIDWrite   : IF/ID enable (0 = stall)
//   ifNop       : flush fetch and redirect to redirectPC
//   redirectPC  : branch/jump target, meaningful with ifNop
//   imemReq     : memory request
//   imemAddr    : registered request address
//   imemAck     : memory response, imemData valid this cycle
//   imemData    : fetched instruction
//   IFIDInst    : IF/ID instruction
//   IFIDPC4     : IF/ID PC+4
//   IFIDValid   : IF/ID holds a real instruction
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcWrite,
    input  logic        IFIDWrite,
    input  logic        ifNop,
    input  logic [31:0] redirectPC,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] IFIDInst,
    output logic [31:0] IFIDPC4,
    output logic        IFIDValid
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic         stall;
    logic         flush;
    logic [31:0]  addr_plus4;
    logic         buf_load;
    logic         buf_clear;
    logic [31:0]  buf_inst;
    logic [31:0]  buf_pc4;
    logic         buf_valid;

    // A stall always wins, so a flush only takes effect in a free cycle.
    assign stall      = ~pcWrite | ~IFIDWrite;
    assign flush      = ifNop & ~stall;
    assign addr_plus4 = imemAddr + 32'd4;

    // Park the instruction that arrives during a stall; leave HOLD empty.
    assign buf_load  = (state == FETCH) & imemAck & stall;
    assign buf_clear = (state == HOLD) & ~stall;

    fetch_buffer u_buffer (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .clear   (buf_clear),
        .inst_in (imemData),
        .pc4_in  (addr_plus4),
        .inst    (buf_inst),
        .pc4     (buf_pc4),
        .valid   (buf_valid)
    );

    // imemAddr only moves when a response has been taken (or no request is
    // in flight, as in HOLD), which keeps it stable for the whole request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            imemAddr  <= RESET_PC;
            imemReq   <= 1'b1;
            IFIDInst  <= NOP_INST;
            IFIDPC4   <= 32'h0;
            IFIDValid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (flush) begin
                        IFIDInst  <= NOP_INST;
                        IFIDPC4   <= 32'h0;
                        IFIDValid <= 1'b0;
                        fetch_pc  <= redirectPC;
                        if (imemAck) begin
                            imemAddr <= redirectPC;
                        end else begin
                            // The old request is still in flight; its data
                            // must be thrown away before redirecting.
                            state <= DROP;
                        end
                    end else if (imemAck) begin
                        if (stall) begin
                            state   <= HOLD;
                            imemReq <= 1'b0;
                        end else begin
                            IFIDInst  <= imemData;
                            IFIDPC4   <= addr_plus4;
                            IFIDValid <= 1'b1;
                            fetch_pc  <= addr_plus4;
                            imemAddr  <= addr_plus4;
                        end
                    end else if (!stall) begin
                        IFIDInst  <= NOP_INST;
                        IFIDPC4   <= 32'h0;
                        IFIDValid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        IFIDInst  <= NOP_INST;
                        IFIDPC4   <= 32'h0;
                        IFIDValid <= 1'b0;
                        fetch_pc  <= redirectPC;
                        imemAddr  <= redirectPC;
                        imemReq   <= 1'b1;
                        state     <= FETCH;
                    end else if (!stall) begin
                        IFIDInst  <= buf_inst;
                        IFIDPC4   <= buf_pc4;
                        IFIDValid <= buf_valid;
                        fetch_pc  <= buf_pc4;
                        imemAddr  <= buf_pc4;
                        imemReq   <= 1'b1;
                        state     <= FETCH;
                    end
                end
                DROP: begin
                    if (!stall) begin
                        IFIDInst  <= NOP_INST;
                        IFIDPC4   <= 32'h0;
                        IFIDValid <= 1'b0;
                    end
                    if (flush && !imemAck) begin
                        fetch_pc <= redirectPC;
                    end else if (flush && imemAck) begin
                        // The stale request completes in the same cycle as
                        // a newer redirect: go straight to the newest target.
                        fetch_pc <= redirectPC;
                        imemAddr <= redirectPC;
                        state    <= FETCH;
                    end else if (imemAck) begin
                        imemAddr <= fetch_pc;
                        state    <= FETCH;
                    end
                end
                default: begin
                    state   <= FETCH;
                    imemReq <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit plus hand-written sequences
// for reset in the middle of a dropped request.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        pcWrite;
    logic        IFIDWrite;
    logic        ifNop;
    logic [31:0] redirectPC;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] IFIDInst;
    logic [31:0] IFIDPC4;
    logic        IFIDValid;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .pcWrite    (pcWrite),
        .IFIDWrite  (IFIDWrite),
        .ifNop      (ifNop),
        .redirectPC (redirectPC),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemData   (imemData),
        .IFIDInst   (IFIDInst),
        .IFIDPC4    (IFIDPC4),
        .IFIDValid  (IFIDValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        pw;
        logic        iw;
        logic        nop;
        logic [31:0] redir;
        logic        ack;
        logic [31:0] data;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc4;
        logic        exp_valid;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic pw, input logic iw, input logic nop,
                                input logic [31:0] redir, input logic ack,
                                input logic [31:0] data, input logic exp_req,
                                input logic [31:0] exp_addr, input logic [31:0] exp_inst,
                                input logic [31:0] exp_pc4, input logic exp_valid);
        vec_t v;
        v.pw = pw; v.iw = iw; v.nop = nop; v.redir = redir;
        v.ack = ack; v.data = data; v.exp_req = exp_req;
        v.exp_addr = exp_addr; v.exp_inst = exp_inst;
        v.exp_pc4 = exp_pc4; v.exp_valid = exp_valid;
        return v;
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic pw, input logic iw, input logic nop,
                                 input logic [31:0] redir, input logic ack,
                                 input logic [31:0] data);
        pcWrite    = pw;
        IFIDWrite  = iw;
        ifNop      = nop;
        redirectPC = redir;
        imemAck    = ack;
        imemData   = data;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic exp_req,
                               input logic [31:0] exp_addr, input logic [31:0] exp_inst,
                               input logic [31:0] exp_pc4, input logic exp_valid);
        checks++;
        if (imemReq !== exp_req) begin
            errors++;
            $display("[TB] FAIL %s imemReq got=%b want=%b", tag, imemReq, exp_req);
        end
        checks++;
        if (imemAddr !== exp_addr) begin
            errors++;
            $display("[TB] FAIL %s imemAddr got=%h want=%h", tag, imemAddr, exp_addr);
        end
        checks++;
        if (IFIDInst !== exp_inst) begin
            errors++;
            $display("[TB] FAIL %s IFIDInst got=%h want=%h", tag, IFIDInst, exp_inst);
        end
        checks++;
        if (IFIDPC4 !== exp_pc4) begin
            errors++;
            $display("[TB] FAIL %s IFIDPC4 got=%h want=%h", tag, IFIDPC4, exp_pc4);
        end
        checks++;
        if (IFIDValid !== exp_valid) begin
            errors++;
            $display("[TB] FAIL %s IFIDValid got=%b want=%b", tag, IFIDValid, exp_valid);
        end
    endtask

    initial begin
        // Zero-wait stream from reset: PC4 = 4, 8, 12, 16.
        vecs[0]  = mk(1,1,0,32'h0,1,32'hA000_0000, 1,32'h04,32'hA000_0000,32'h04,1);
        vecs[1]  = mk(1,1,0,32'h0,1,32'hA000_0001, 1,32'h08,32'hA000_0001,32'h08,1);
        vecs[2]  = mk(1,1,0,32'h0,1,32'hA000_0002, 1,32'h0C,32'hA000_0002,32'h0C,1);
        vecs[3]  = mk(1,1,0,32'h0,1,32'hA000_0003, 1,32'h10,32'hA000_0003,32'h10,1);
        // Ack for 0x10 during a 3-cycle IF/ID stall, then release from HOLD.
        vecs[4]  = mk(1,0,0,32'h0,1,32'hB000_0010, 0,32'h10,32'hA000_0003,32'h10,1);
        vecs[5]  = mk(1,0,0,32'h0,0,32'h0,         0,32'h10,32'hA000_0003,32'h10,1);
        vecs[6]  = mk(1,0,0,32'h0,0,32'h0,         0,32'h10,32'hA000_0003,32'h10,1);
        vecs[7]  = mk(1,1,0,32'h0,0,32'h0,         1,32'h14,32'hB000_0010,32'h14,1);
        // Walk to 0x20 then flush while the 0x20 request is outstanding.
        vecs[8]  = mk(1,1,0,32'h0,1,32'hA000_0014, 1,32'h18,32'hA000_0014,32'h18,1);
        vecs[9]  = mk(1,1,0,32'h0,1,32'hA000_0018, 1,32'h1C,32'hA000_0018,32'h1C,1);
        vecs[10] = mk(1,1,0,32'h0,1,32'hA000_001C, 1,32'h20,32'hA000_001C,32'h20,1);
        vecs[11] = mk(1,1,1,32'h40,0,32'h0,        1,32'h20,32'h0,32'h0,0);
        vecs[12] = mk(1,1,0,32'h0,0,32'h0,         1,32'h20,32'h0,32'h0,0);
        vecs[13] = mk(1,1,0,32'h0,1,32'hDEAD_0020, 1,32'h40,32'h0,32'h0,0);
        vecs[14] = mk(1,1,0,32'h0,1,32'hA000_0040, 1,32'h44,32'hA000_0040,32'h44,1);
        // Flush under an IF/ID stall is ignored; pcWrite=0 also holds.
        vecs[15] = mk(1,0,1,32'h80,0,32'h0,        1,32'h44,32'hA000_0040,32'h44,1);
        vecs[16] = mk(1,1,0,32'h0,1,32'hA000_0044, 1,32'h48,32'hA000_0044,32'h48,1);
        vecs[17] = mk(0,1,1,32'h90,0,32'h0,        1,32'h48,32'hA000_0044,32'h48,1);
        // Flush coinciding with an ack: data dropped, redirect at once.
        vecs[18] = mk(1,1,1,32'h100,1,32'hDEAD_0048,1,32'h100,32'h0,32'h0,0);
        vecs[19] = mk(1,1,0,32'h0,1,32'hA000_0100, 1,32'h104,32'hA000_0100,32'h104,1);
        // Address wrap at the top of the space.
        vecs[20] = mk(1,1,1,32'hFFFF_FFFC,1,32'hDEAD_0104,1,32'hFFFF_FFFC,32'h0,32'h0,0);
        vecs[21] = mk(1,1,0,32'h0,1,32'hA000_FFFC, 1,32'h0,32'hA000_FFFC,32'h0,1);
        vecs[22] = mk(1,1,0,32'h0,0,32'h0,         1,32'h0,32'h0,32'h0,0);
        // Flush out of HOLD discards the buffered instruction.
        vecs[23] = mk(1,0,0,32'h0,1,32'hC000_0000, 0,32'h0,32'h0,32'h0,0);
        vecs[24] = mk(1,1,1,32'h200,0,32'h0,       1,32'h200,32'h0,32'h0,0);
        vecs[25] = mk(1,1,0,32'h0,1,32'hA000_0200, 1,32'h204,32'hA000_0200,32'h204,1);
        // Second flush while in DROP retargets to the newest address.
        vecs[26] = mk(1,1,1,32'h300,0,32'h0,       1,32'h204,32'h0,32'h0,0);
        vecs[27] = mk(1,1,1,32'h400,0,32'h0,       1,32'h204,32'h0,32'h0,0);
        vecs[28] = mk(1,1,0,32'h0,1,32'hDEAD_0204, 1,32'h400,32'h0,32'h0,0);
        vecs[29] = mk(1,1,0,32'h0,1,32'hA000_0400, 1,32'h404,32'hA000_0400,32'h404,1);

        rst        = 1'b0;
        pcWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        ifNop      = 1'b0;
        redirectPC = 32'h0;
        imemAck    = 1'b0;
        imemData   = 32'h0;

        #12;
        checkOutput("reset", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].pw, vecs[i].iw, vecs[i].nop, vecs[i].redir,
                          vecs[i].ack, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                        vecs[i].exp_inst, vecs[i].exp_pc4, vecs[i].exp_valid);
        end

        // Enter DROP with the 0x404 request outstanding, then reset.
        applyStimulus(1, 1, 1, 32'h500, 0, 32'h0);
        checkOutput("drop_entry", 1'b1, 32'h404, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("reset_in_drop", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        ifNop = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, 1, 0, 32'h0, 0, 32'h0);
        checkOutput("post_reset_wait", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1, 1, 0, 32'h0, 1, 32'hE000_0000);
        checkOutput("post_reset_first", 1'b1, 32'h4, 32'hE000_0000, 32'h4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
